// File: rtl/pll_vreg_ramp_ctrl.sv
// rtl/pll_vreg_ramp_ctrl.sv - PLL analog supply soft-start ramp and power-good controller
//
// Ports:
//   clk_i        : clock
//   rst_ni       : synchronous reset, active-low
//   en_i         : supply enable request
//   target_uv_i  : requested supply level (uV), latched on OFF->RAMP_UP
//   sense_uv_i   : sensed supply level (uV)
//   vout_uv_o    : commanded supply level (uV)
//   supply_on_o  : vout_uv_o inside the ON window (registered)
//   ramp_busy_o  : ramping up/down, or discharging in FAULT
//   power_good_o : debounced power-good, high only in ON (registered)
//   fault_o      : sticky fault, cleared on OFF entry or reset
//   state_o      : current FSM state for debug
module pll_vreg_ramp_ctrl #(
  parameter int VW             = 21,
  parameter int STEP_UV        = 10000,
  parameter int STEP_DIV       = 4,
  parameter int ON_MIN_UV      = 810000,
  parameter int ON_MAX_UV      = 1320000,
  parameter int PG_DEBOUNCE    = 8,
  parameter int SETTLE_TIMEOUT = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [VW-1:0] target_uv_i,
  input  logic [VW-1:0] sense_uv_i,
  output logic [VW-1:0] vout_uv_o,
  output logic          supply_on_o,
  output logic          ramp_busy_o,
  output logic          power_good_o,
  output logic          fault_o,
  output logic [2:0]    state_o
);

  localparam int PW = $clog2(STEP_DIV + 1);
  localparam int CW = $clog2(PG_DEBOUNCE + 1);
  localparam int TW = $clog2(SETTLE_TIMEOUT + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(PG_DEBOUNCE - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(SETTLE_TIMEOUT - 1);
  localparam logic [VW-1:0] STEP_V     = VW'(STEP_UV);
  localparam logic [VW-1:0] ON_MIN_V   = VW'(ON_MIN_UV);
  localparam logic [VW-1:0] ON_MAX_V   = VW'(ON_MAX_UV);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ON        = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vout_q, vout_d;
  logic [VW-1:0] tgt_q, tgt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          reached_q, reached_d;
  logic          supply_on_q, power_good_q, fault_q;

  logic          step;
  logic          win;
  logic [VW:0]   up_sum;
  logic [VW-1:0] up_val;
  logic [VW-1:0] dn_val;
  logic [VW-1:0] tgt_clamped;

  function automatic logic in_window(input logic [VW-1:0] v);
    return (v >= ON_MIN_V) && (v <= ON_MAX_V);
  endfunction

  // Step arithmetic: one extra bit on the way up so the sum cannot wrap
  // before it is clamped to the latched target.
  always_comb begin
    step        = (presc_q == PRESC_LAST);
    win         = in_window(sense_uv_i);
    up_sum      = {1'b0, vout_q} + {1'b0, STEP_V};
    up_val      = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[VW-1:0];
    dn_val      = (vout_q >= STEP_V) ? (vout_q - STEP_V) : '0;
    tgt_clamped = (target_uv_i > ON_MAX_V) ? ON_MAX_V : target_uv_i;
  end

  always_comb begin
    state_d   = state_q;
    vout_d    = vout_q;
    tgt_d     = tgt_q;
    reached_d = reached_q;
    win_cnt_d = win_cnt_q;
    to_cnt_d  = to_cnt_q;
    presc_d   = step ? '0 : presc_q + PW'(1);

    case (state_q)
      ST_OFF: begin
        if (en_i) begin
          state_d = ST_RAMP_UP;
          tgt_d   = tgt_clamped;
        end
      end

      ST_RAMP_UP: begin
        // reached_q is set by the step that lands on the target, so the
        // move to SETTLE happens one cycle later (also for a zero target).
        if (!en_i) begin
          state_d = ST_RAMP_DOWN;
        end else if (reached_q) begin
          state_d = ST_SETTLE;
        end else if (step) begin
          vout_d    = up_val;
          reached_d = (up_val == tgt_q);
        end
      end

      ST_SETTLE: begin
        to_cnt_d  = to_cnt_q + TW'(1);
        win_cnt_d = win ? win_cnt_q + CW'(1) : '0;
        if (!en_i) begin
          state_d = ST_RAMP_DOWN;
        end else if (win && (win_cnt_q == DB_LAST)) begin
          state_d = ST_ON;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
        end
      end

      ST_ON: begin
        // Same counter as in SETTLE, now counting out-of-window cycles.
        win_cnt_d = win ? '0 : win_cnt_q + CW'(1);
        if (!en_i) begin
          state_d = ST_RAMP_DOWN;
        end else if (!win && (win_cnt_q == DB_LAST)) begin
          state_d = ST_FAULT;
        end
      end

      ST_RAMP_DOWN: begin
        if (vout_q == '0) begin
          state_d = ST_OFF;
        end else if (step) begin
          vout_d = dn_val;
        end
      end

      ST_FAULT: begin
        if (vout_q == '0) begin
          if (!en_i) begin
            state_d = ST_OFF;
          end
        end else if (step) begin
          vout_d = dn_val;
        end
      end

      default: begin
        state_d = ST_OFF;
        vout_d  = '0;
      end
    endcase

    // Every state entry restarts the prescaler and the per-state counters.
    if (state_d != state_q) begin
      presc_d   = '0;
      reached_d = 1'b0;
      win_cnt_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_OFF;
      vout_q       <= '0;
      tgt_q        <= '0;
      presc_q      <= '0;
      win_cnt_q    <= '0;
      to_cnt_q     <= '0;
      reached_q    <= 1'b0;
      supply_on_q  <= 1'b0;
      power_good_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vout_q       <= vout_d;
      tgt_q        <= tgt_d;
      presc_q      <= presc_d;
      win_cnt_q    <= win_cnt_d;
      to_cnt_q     <= to_cnt_d;
      reached_q    <= reached_d;
      // Registered from next values so they line up with vout_uv_o/state_o.
      supply_on_q  <= in_window(vout_d);
      power_good_q <= (state_d == ST_ON);
      if (state_d == ST_FAULT) begin
        fault_q <= 1'b1;
      end else if (state_d == ST_OFF) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign vout_uv_o    = vout_q;
  assign supply_on_o  = supply_on_q;
  assign power_good_o = power_good_q;
  assign fault_o      = fault_q;
  assign state_o      = state_q;
  assign ramp_busy_o  = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                        ((state_q == ST_FAULT) && (vout_q != '0));

endmodule
